// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - register-file write-port arbiter bus interface
//
// Groups the pipeline writeback request, the multiply/divide result offer,
// and the register-file write port with its status flags.
//   pipe_we/pipe_rd/pipe_data   : pipeline writeback request (to arbiter)
//   md_valid/md_rd/md_data      : multiply/divide result offer (to arbiter)
//   md_ready                    : result queue can accept (from arbiter)
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : registered write port
//   pending_mask                : registers targeted by queued results
//   stall_pipe                  : asks the pipeline to withhold writebacks
//   proto_err                   : sticky protocol-violation flag
// modport slave is the arbiter's view; modport master is the driver's view.

interface wb_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] pending_mask;
    logic        stall_pipe;
    logic        proto_err;

    modport slave (
        input  pipe_we, pipe_rd, pipe_data,
        input  md_valid, md_rd, md_data,
        output md_ready,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output pending_mask, stall_pipe, proto_err
    );

    modport master (
        output pipe_we, pipe_rd, pipe_data,
        output md_valid, md_rd, md_data,
        input  md_ready,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  pending_mask, stall_pipe, proto_err
    );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter with 2-entry mul/div result queue
//
// Ports:
//   clock : rising-edge clock for all state
//   reset : asynchronous active-high reset
//   bus   : wb_arbiter_if.slave (pipeline request, mul/div offer, write port)
//
// The pipeline normally owns the single register-file write port; mul/div
// results wait in a 2-entry FIFO and drain in idle pipeline cycles. An age
// counter on the head raises stall_pipe when the head has waited too long,
// after which the head wins the port. A pipeline write arriving while stalled
// is dropped and recorded in the sticky proto_err flag.

module wb_arbiter (
    input  logic         clock,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    // Slot 0 is always the head; slot 1 is only meaningful when count is 2.
    entry_t      slot0_q, slot0_d;
    entry_t      slot1_q, slot1_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  age_q, age_d;
    logic        stall_q, stall_d;
    logic        err_q, err_d;
    logic [31:0] mask_q, mask_d;
    logic        we_q, we_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;

    logic        preq;
    logic        md_ready;
    logic        enq;
    logic        deq;
    entry_t      new_entry;
    entry_t      head_mid;
    logic [1:0]  count_mid;

    always_comb begin
        preq      = bus.pipe_we & (bus.pipe_rd != 5'd0);
        md_ready  = (count_q < 2'd2);
        // An offer to r0 is accepted (md_ready is honoured) but never stored.
        enq       = bus.md_valid & md_ready & (bus.md_rd != 5'd0);
        new_entry = '{rd: bus.md_rd, data: bus.md_data};

        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        deq     = 1'b0;
        err_d   = err_q;

        // While stalled the pipeline must not write; a request anyway is
        // dropped and flagged.
        if (stall_q && preq) begin
            err_d = 1'b1;
        end

        if (stall_q && (count_q != 2'd0)) begin
            we_d    = 1'b1;
            wreg_d  = slot0_q.rd;
            wdata_d = slot0_q.data;
            deq     = 1'b1;
        end else if (preq && !stall_q) begin
            we_d    = 1'b1;
            wreg_d  = bus.pipe_rd;
            wdata_d = bus.pipe_data;
        end else if (count_q != 2'd0) begin
            we_d    = 1'b1;
            wreg_d  = slot0_q.rd;
            wdata_d = slot0_q.data;
            deq     = 1'b1;
        end

        // Dequeue first, then append behind whatever remains so a same-edge
        // enqueue/dequeue keeps arrival order.
        head_mid  = (deq && (count_q == 2'd2)) ? slot1_q : slot0_q;
        count_mid = count_q - {1'b0, deq};

        slot0_d = head_mid;
        slot1_d = slot1_q;
        if (enq) begin
            if (count_mid == 2'd0) begin
                slot0_d = new_entry;
            end else begin
                slot1_d = new_entry;
            end
        end
        count_d = count_mid + {1'b0, enq};

        mask_d = 32'd0;
        if (count_d != 2'd0) begin
            mask_d[slot0_d.rd] = 1'b1;
        end
        if (count_d == 2'd2) begin
            mask_d[slot1_d.rd] = 1'b1;
        end

        age_d = age_q;
        if (deq || (count_q == 2'd0)) begin
            age_d = 2'd0;
        end else if (age_q != 2'd3) begin
            age_d = age_q + 2'd1;
        end

        // Stall rises one edge after the age saturates and falls on the edge
        // that dequeues the head.
        if (deq) begin
            stall_d = 1'b0;
        end else begin
            stall_d = stall_q | (age_q == 2'd3);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
            age_q   <= 2'd0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= 32'd0;
            we_q    <= 1'b0;
            wreg_q  <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
            age_q   <= age_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.md_ready         = md_ready;
    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;
    assign bus.pending_mask     = mask_q;
    assign bus.stall_pipe       = stall_q;
    assign bus.proto_err        = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter

module tb_wb_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic we, input logic [4:0] rd, input logic [31:0] data);
        bus.pipe_we   = we;
        bus.pipe_rd   = rd;
        bus.pipe_data = data;
    endtask

    task automatic set_md(input logic v, input logic [4:0] rd, input logic [31:0] data);
        bus.md_valid = v;
        bus.md_rd    = rd;
        bus.md_data  = data;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
        check_eq({tag, "_we"},   32'(bus.ctrl_writeEnable), 32'(we));
        check_eq({tag, "_reg"},  32'(bus.ctrl_writeReg), 32'(rd));
        check_eq({tag, "_data"}, bus.data_writeReg, data);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_md(1'b0, 5'd0, 32'd0);
        repeat (2) tick();

        // Reset state
        check_wr("rst", 1'b0, 5'd0, 32'd0);
        check_eq("rst_mask", bus.pending_mask, 32'd0);
        check_eq("rst_ready", 32'(bus.md_ready), 32'd1);
        check_eq("rst_stall", 32'(bus.stall_pipe), 32'd0);
        check_eq("rst_err", 32'(bus.proto_err), 32'd0);
        rst = 1'b0;
        tick();

        // Pipeline path, then idle keeps address/data
        set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check_wr("pipe", 1'b1, 5'd5, 32'hDEADBEEF);
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();
        check_wr("idle", 1'b0, 5'd5, 32'hDEADBEEF);

        // Queue two results behind a busy pipeline, then drain in order
        set_pipe(1'b1, 5'd7, 32'h77);
        set_md(1'b1, 5'd3, 32'h11);
        tick();
        check_eq("q1_mask", bus.pending_mask, 32'h0000_0008);
        check_eq("q1_ready", 32'(bus.md_ready), 32'd1);
        set_md(1'b1, 5'd4, 32'h22);
        tick();
        check_eq("q2_mask", bus.pending_mask, 32'h0000_0018);
        check_eq("q2_ready", 32'(bus.md_ready), 32'd0);
        check_wr("q2_pipe", 1'b1, 5'd7, 32'h77);
        set_md(1'b0, 5'd0, 32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();
        check_wr("drain1", 1'b1, 5'd3, 32'h11);
        check_eq("drain1_mask", bus.pending_mask, 32'h0000_0010);
        tick();
        check_wr("drain2", 1'b1, 5'd4, 32'h22);
        check_eq("drain2_mask", bus.pending_mask, 32'd0);
        check_eq("drain2_ready", 32'(bus.md_ready), 32'd1);
        tick();
        check_eq("drain_idle_we", 32'(bus.ctrl_writeEnable), 32'd0);

        // r0 handling: neither source counts as a write, r0 offer takes no slot
        set_pipe(1'b1, 5'd0, 32'hBAD0);
        set_md(1'b1, 5'd0, 32'hBAD1);
        tick();
        check_eq("r0_we", 32'(bus.ctrl_writeEnable), 32'd0);
        check_eq("r0_mask", bus.pending_mask, 32'd0);
        set_pipe(1'b1, 5'd6, 32'h66);
        set_md(1'b1, 5'd9, 32'h99);
        tick();
        set_md(1'b1, 5'd0, 32'hBAD2);
        tick();
        check_eq("r0q_mask", bus.pending_mask, 32'h0000_0200);
        check_eq("r0q_ready", 32'(bus.md_ready), 32'd1);
        set_md(1'b1, 5'd10, 32'hAA);
        tick();
        check_eq("r0q2_ready", 32'(bus.md_ready), 32'd0);
        check_eq("r0q2_mask", bus.pending_mask, 32'h0000_0600);
        set_md(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd0, 32'hBAD3);
        tick();
        check_wr("r0_drain1", 1'b1, 5'd9, 32'h99);
        tick();
        check_wr("r0_drain2", 1'b1, 5'd10, 32'hAA);
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();

        // Starvation: head ages under constant pipeline traffic
        set_pipe(1'b1, 5'd1, 32'h1001);
        set_md(1'b1, 5'd12, 32'hC);
        tick();
        set_md(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("starve_no_stall", 32'(bus.stall_pipe), 32'd0);
        end
        tick();
        check_eq("starve_stall", 32'(bus.stall_pipe), 32'd1);
        check_wr("starve_pipe", 1'b1, 5'd1, 32'h1001);
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();
        check_wr("starve_head", 1'b1, 5'd12, 32'hC);
        check_eq("starve_clear", 32'(bus.stall_pipe), 32'd0);
        check_eq("starve_err", 32'(bus.proto_err), 32'd0);

        // Protocol error: pipeline writes while stalled
        set_pipe(1'b1, 5'd2, 32'h2002);
        set_md(1'b1, 5'd13, 32'hD);
        tick();
        set_md(1'b0, 5'd0, 32'd0);
        repeat (4) tick();
        check_eq("perr_stall", 32'(bus.stall_pipe), 32'd1);
        set_pipe(1'b1, 5'd2, 32'h2222);
        tick();
        check_wr("perr_head", 1'b1, 5'd13, 32'hD);
        check_eq("perr_err", 32'(bus.proto_err), 32'd1);
        check_eq("perr_stall_clr", 32'(bus.stall_pipe), 32'd0);
        tick();
        check_wr("perr_pipe", 1'b1, 5'd2, 32'h2222);
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();
        check_eq("perr_sticky", 32'(bus.proto_err), 32'd1);

        // Reset with two entries queued
        set_pipe(1'b1, 5'd1, 32'h1);
        set_md(1'b1, 5'd20, 32'h20);
        tick();
        set_md(1'b1, 5'd21, 32'h21);
        tick();
        check_eq("mid_mask", bus.pending_mask, 32'h0030_0000);
        check_eq("mid_ready", 32'(bus.md_ready), 32'd0);
        #2;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_md(1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        #1;
        check_wr("async_rst", 1'b0, 5'd0, 32'd0);
        check_eq("async_mask", bus.pending_mask, 32'd0);
        check_eq("async_ready", 32'(bus.md_ready), 32'd1);
        check_eq("async_err", 32'(bus.proto_err), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_rst_we", 32'(bus.ctrl_writeEnable), 32'd0);
        end
        check_eq("post_rst_mask", bus.pending_mask, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have: clock  input  1  rising-edge clock for all state.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high reset of all state.
REQ-003 SHALL have: pipe_we  input  1  pipeline writeback request this cycle.
REQ-004 SHALL have: pipe_rd  input  5  pipeline destination register.
REQ-005 SHALL have: pipe_data  input  32  pipeline writeback value.
REQ-006 SHALL have: md_valid  input  1  multiply/divide result offered.
REQ-007 SHALL have: md_rd  input  5  multiply/divide destination register.
REQ-008 SHALL have: md_data  input  32  multiply/divide result value.
REQ-009 SHALL have: md_ready  output  1  result queue can accept; md_ready = (count < 2), combinational from registered count.
REQ-010 SHALL have: ctrl_writeEnable  output  1  registered write enable to the register file.
REQ-011 SHALL have: ctrl_writeReg  output  5  registered write address to the register file.
REQ-012 SHALL have: data_writeReg  output  32  registered write data to the register file.
REQ-013 SHALL have: pending_mask  output  32  registered; bit n = 1 iff a queued multiply/divide entry targets register n.
REQ-014 SHALL have: stall_pipe  output  1  registered; requests the pipeline to withhold writebacks.
REQ-015 SHALL have: proto_err  output  1  registered, sticky protocol-violation flag.

Function
REQ-016 SHALL contain a 2-entry FIFO of {rd[4:0], data[31:0]} plus a 2-bit count (0..2).
REQ-017 SHALL enqueue md_rd/md_data on a clock edge where md_valid=1, md_ready=1 and md_rd!=0.
REQ-018 SHALL accept and discard (no enqueue, no write) an offer with md_valid=1, md_ready=1, md_rd=0.
REQ-019 SHALL treat pipe_we=1 with pipe_rd=0 as no request.
REQ-020 SHALL define the effective pipeline request as preq = pipe_we & (pipe_rd!=0).
REQ-021 SHALL, when preq=1 and stall_pipe=0, register {1, pipe_rd, pipe_data} onto the write port at the next edge; the FIFO is not dequeued.
REQ-022 SHALL, when preq=0 and count>0, register {1, head.rd, head.data} onto the write port at the next edge and dequeue the head.
REQ-023 SHALL, when stall_pipe=1 and count>0, give the FIFO head priority over preq as in REQ-022.
REQ-024 SHALL, when stall_pipe=1 and preq=1 in the same cycle: drop the pipeline request, set proto_err=1, and leave it set until reset.
REQ-025 SHALL register ctrl_writeEnable=0 (ctrl_writeReg and data_writeReg hold their previous values) when no source is selected.
REQ-026 SHALL have a latency of exactly one cycle from the selecting edge to the write-port outputs; no combinational path from inputs to the write port.
REQ-027 SHALL allow enqueue and dequeue on the same edge; count is unchanged and the new entry lands behind the remaining entry.
REQ-028 SHALL hold a 2-bit saturating age counter:
  - cleared on any dequeue or when count=0;
  - incremented on each edge where count>0 and no dequeue occurs.
REQ-029 SHALL assert stall_pipe on the edge after age reaches 3 and keep it asserted until the edge after the dequeue of the head.
REQ-030 SHALL drain FIFO entries in arrival order; writes to the same register are neither merged nor reordered.
REQ-031 SHALL update pending_mask on the same edge as the FIFO state: OR of one-hot(rd) over valid entries.

Reset
REQ-032 SHALL, while reset=1, force: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, count=0, age=0, pending_mask=0, stall_pipe=0, proto_err=0; md_ready then reads 1.
REQ-033 SHALL discard queued entries on reset asserted mid-operation; no write to the register file is issued for them after reset.

Verification
REQ-034 SHALL cover pipeline path: pipe_we=1, pipe_rd=5, pipe_data=0xDEADBEEF -> next edge: ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; following idle cycle: ctrl_writeEnable=0.
REQ-035 SHALL cover queue and drain: md offers rd=3/0x11 then rd=4/0x22 while pipe_we=1 (rd=7) -> md_ready=0 after the second, pending_mask=0x18; then pipe_we=0 -> writes r3=0x11 then r4=0x22; pending_mask returns to 0.
REQ-036 SHALL cover starvation: one queued entry with pipe_we=1 (rd!=0) every cycle -> stall_pipe=1 after age saturates; with pipe_we then 0 the head is written next edge and stall_pipe clears.
REQ-037 SHALL cover protocol error: stall_pipe=1 with pipe_we=1 -> head written, pipeline write dropped, proto_err=1 held until reset.
REQ-038 SHALL cover r0 handling: pipe_rd=0 or md_rd=0 -> no ctrl_writeEnable; the md offer consumes no FIFO slot (count unchanged).
REQ-039 SHALL cover reset mid-queue: reset asserted with count=2 -> outputs zero immediately (asynchronously), md_ready=1, and no stale write after reset deasserts.
